// File: rtl/axil_bram_master.sv
// AXI4-Lite slave that bridges single-beat transactions onto a one-port register-file (BRAM) port.
// Exactly one transaction is outstanding; reads wait a fixed READ_LATENCY before responding.
module axil_bram_master #(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        user_clk,
  input  logic        user_areset,
  input  logic        s_axil_awvalid,
  output logic        s_axil_awready,
  input  logic [11:0] s_axil_awaddr,
  input  logic        s_axil_wvalid,
  output logic        s_axil_wready,
  input  logic [31:0] s_axil_wdata,
  input  logic [3:0]  s_axil_wstrb,
  output logic        s_axil_bvalid,
  input  logic        s_axil_bready,
  output logic [1:0]  s_axil_bresp,
  input  logic        s_axil_arvalid,
  output logic        s_axil_arready,
  input  logic [11:0] s_axil_araddr,
  output logic        s_axil_rvalid,
  input  logic        s_axil_rready,
  output logic [31:0] s_axil_rdata,
  output logic [1:0]  s_axil_rresp,
  output logic        bram_en_a,
  output logic [3:0]  bram_we_a,
  output logic [11:0] bram_addr_a,
  output logic [31:0] bram_wrdata_a,
  input  logic [31:0] bram_rddata_a
);

  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic        rr_q, rr_d;  // 1: read wins the next contended grant
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        en_q, en_d;
  logic [3:0]  we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wrdata_q, wrdata_d;
  logic        wr_req, rd_req, grant_wr, grant_rd, idle;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  assign idle     = (state_q == IDLE);
  assign wr_req   = s_axil_awvalid & s_axil_wvalid;
  assign rd_req   = s_axil_arvalid;
  assign grant_wr = wr_req & (~rd_req | ~rr_q);
  assign grant_rd = rd_req & (~wr_req | rr_q);

  assign s_axil_awready = idle & grant_wr;
  assign s_axil_wready  = idle & grant_wr;
  assign s_axil_arready = idle & grant_rd;
  assign s_axil_bvalid  = (state_q == WR_RESP);
  assign s_axil_bresp   = 2'b00;
  assign s_axil_rvalid  = (state_q == RD_RESP);
  assign s_axil_rresp   = 2'b00;
  assign s_axil_rdata   = rdata_q;
  assign bram_en_a      = en_q;
  assign bram_we_a      = we_q;
  assign bram_addr_a    = addr_q;
  assign bram_wrdata_a  = wrdata_q;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    en_d     = 1'b0;
    we_d     = 4'h0;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_wr) begin
          rr_d = ~rr_q;
          if (s_axil_wstrb != 4'h0) begin
            state_d  = WR_ISSUE;
            en_d     = 1'b1;
            we_d     = 4'hF;
            addr_d   = {s_axil_awaddr[11:2], 2'b00};
            wrdata_d = s_axil_wdata;
          end else begin
            state_d = WR_RESP;
          end
        end else if (grant_rd) begin
          rr_d    = ~rr_q;
          state_d = RD_ISSUE;
          en_d    = 1'b1;
          addr_d  = {s_axil_araddr[11:2], 2'b00};
        end
      end
      WR_ISSUE: state_d = WR_RESP;
      WR_RESP:  if (s_axil_bready) state_d = IDLE;
      RD_ISSUE: begin
        state_d = RD_WAIT;
        cnt_d   = CNT_LOAD;
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = bram_rddata_a;
          state_d = RD_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_RESP:  if (s_axil_rready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or posedge user_areset) begin
    if (user_areset) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      cnt_q    <= 4'd0;
      rdata_q  <= 32'h0;
      en_q     <= 1'b0;
      we_q     <= 4'h0;
      addr_q   <= 12'h0;
      wrdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
    end
  end

endmodule

// File: tb/tb_axil_bram_master.sv
// Scoreboard bench for axil_bram_master: a BRAM model with READ_LATENCY pipeline, a word-array
// reference memory, and a negedge monitor that checks BRAM strobes and AXI responses.
module tb_axil_bram_master;
  localparam int unsigned L = 2;

  logic        user_clk = 1'b0;
  logic        user_areset;
  logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [11:0] s_axil_awaddr, s_axil_araddr;
  logic [31:0] s_axil_wdata, s_axil_rdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic        s_axil_rvalid, s_axil_rready;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic        bram_en_a;
  logic [3:0]  bram_we_a;
  logic [11:0] bram_addr_a;
  logic [31:0] bram_wrdata_a, bram_rddata_a;

  always #5 user_clk = ~user_clk;

  axil_bram_master #(.READ_LATENCY(L)) dut (
    .user_clk(user_clk), .user_areset(user_areset),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_awaddr(s_axil_awaddr),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .s_axil_bresp(s_axil_bresp),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_araddr(s_axil_araddr),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .bram_en_a(bram_en_a), .bram_we_a(bram_we_a), .bram_addr_a(bram_addr_a),
    .bram_wrdata_a(bram_wrdata_a), .bram_rddata_a(bram_rddata_a)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0: ready high, 1: random, 2: bready low, 3: rready low

  logic [31:0] bram_mem [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] pipe_d [L];
  logic        pipe_v [L];

  typedef struct { bit is_rd; logic [31:0] data; } resp_t;
  typedef struct { logic [3:0] we; logic [11:0] addr; logic [31:0] wdata; } acc_t;
  resp_t resp_q[$];
  acc_t  acc_q[$];

  always @(posedge user_clk) cyc <= cyc + 1;

  // BRAM port model: read data is only meaningful in the cycle L after the strobe.
  always @(posedge user_clk) begin
    if (bram_en_a && bram_we_a == 4'hF) bram_mem[bram_addr_a[11:2]] <= bram_wrdata_a;
    pipe_v[0] <= bram_en_a && (bram_we_a == 4'h0);
    pipe_d[0] <= bram_mem[bram_addr_a[11:2]];
    for (int i = 1; i < L; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign bram_rddata_a = (pipe_v[L-1] === 1'b1) ? pipe_d[L-1] : 32'hBAD0_BAD0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge user_clk);
    #2;
    unique case (rdy_mode)
      1:       begin s_axil_bready = ($urandom_range(0, 3) != 0);
                     s_axil_rready = ($urandom_range(0, 3) != 0); end
      2:       begin s_axil_bready = 1'b0; s_axil_rready = 1'b1; end
      3:       begin s_axil_bready = 1'b1; s_axil_rready = 1'b0; end
      default: begin s_axil_bready = 1'b1; s_axil_rready = 1'b1; end
    endcase
  end

  // Monitor
  initial begin
    int last_en = -100, t_rd_en = 0, t_wr_en = 0;
    bit wr_pending = 0, bv_p = 0, bb_p = 0, rv_p = 0, rr_p = 0;
    logic [31:0] rdata_p = 0;
    resp_t r;
    acc_t a;
    forever begin
      @(negedge user_clk);
      if (bram_en_a) begin
        check("en_spacing_ok", 32'(cyc - last_en >= 3), 1);
        if (acc_q.size() == 0) check("unexpected_en", 1, 0);
        else begin
          a = acc_q.pop_front();
          check("bram_we", bram_we_a, a.we);
          check("bram_addr", bram_addr_a, a.addr);
          if (a.we != 4'h0) check("bram_wrdata", bram_wrdata_a, a.wdata);
        end
        last_en = cyc;
        if (bram_we_a == 4'h0) t_rd_en = cyc;
        else begin t_wr_en = cyc; wr_pending = 1; end
      end else if (bram_we_a != 4'h0) check("we_without_en", bram_we_a, 0);
      if (s_axil_awready !== s_axil_wready) check("aw_w_ready_pair", s_axil_awready, s_axil_wready);
      if ((s_axil_bvalid || s_axil_rvalid) && (s_axil_awready || s_axil_arready))
        check("ready_outside_idle", 1, 0);
      if (s_axil_bvalid && !bv_p && wr_pending) begin
        check("bvalid_latency", 32'(cyc - t_wr_en), 1);
        wr_pending = 0;
      end
      if (s_axil_rvalid && !rv_p) check("rvalid_latency", 32'(cyc - t_rd_en), L + 1);
      if (s_axil_rvalid && rv_p && !rr_p) check("rdata_stable", s_axil_rdata, rdata_p);
      if (s_axil_bvalid && s_axil_bready && bv_p && bb_p) check("b_single_cycle", 1, 0);
      if (s_axil_rvalid && s_axil_rready && rv_p && rr_p) check("r_single_cycle", 1, 0);
      if ((s_axil_bvalid && s_axil_bready) || (s_axil_rvalid && s_axil_rready)) begin
        if (resp_q.size() == 0) check("unexpected_response", 1, 0);
        else begin
          r = resp_q.pop_front();
          check("resp_kind_is_rd", 32'(s_axil_rvalid), 32'(r.is_rd));
          if (r.is_rd) begin
            check("rdata", s_axil_rdata, r.data);
            check("rresp", s_axil_rresp, 0);
          end else check("bresp", s_axil_bresp, 0);
        end
      end
      bv_p = s_axil_bvalid; bb_p = s_axil_bready;
      rv_p = s_axil_rvalid; rr_p = s_axil_rready; rdata_p = s_axil_rdata;
    end
  end

  task automatic exp_write(input logic [11:0] ad, input logic [31:0] d, input logic [3:0] s);
    resp_t r;
    acc_t a;
    if (s != 4'h0) begin
      a.we = 4'hF; a.addr = {ad[11:2], 2'b00}; a.wdata = d;
      acc_q.push_back(a);
      ref_mem[ad[11:2]] = d;
    end
    r.is_rd = 0; r.data = 0;
    resp_q.push_back(r);
  endtask

  task automatic exp_read(input logic [11:0] ad);
    resp_t r;
    acc_t a;
    a.we = 4'h0; a.addr = {ad[11:2], 2'b00}; a.wdata = 0;
    acc_q.push_back(a);
    r.is_rd = 1; r.data = ref_mem[ad[11:2]];
    resp_q.push_back(r);
  endtask

  task automatic drive_write(input logic [11:0] ad, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    s_axil_awaddr = ad; s_axil_wdata = d; s_axil_wstrb = s;
    s_axil_awvalid = 1; s_axil_wvalid = 1;
    @(negedge user_clk);
    while (!(s_axil_awready && s_axil_wready) && n < 200) begin n++; @(negedge user_clk); end
    if (n >= 200) check("write_accept_timeout", 1, 0);
    @(posedge user_clk);
    #1;
    s_axil_awvalid = 0; s_axil_wvalid = 0;
  endtask

  task automatic drive_read(input logic [11:0] ad);
    int n = 0;
    s_axil_araddr = ad; s_axil_arvalid = 1;
    @(negedge user_clk);
    while (!s_axil_arready && n < 200) begin n++; @(negedge user_clk); end
    if (n >= 200) check("read_accept_timeout", 1, 0);
    @(posedge user_clk);
    #1;
    s_axil_arvalid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (resp_q.size() != 0 && n < 400) begin n++; @(negedge user_clk); end
    if (n >= 400) check("response_timeout", 1, 0);
    @(posedge user_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"}, {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid,
                            s_axil_rvalid, s_axil_bresp, s_axil_rresp, bram_en_a, bram_we_a}, 0);
    check({name, "_addr"}, bram_addr_a, 0);
    check({name, "_wrdata"}, bram_wrdata_a, 0);
    check({name, "_rdata"}, s_axil_rdata, 0);
  endtask

  task automatic reset_pulse();
    user_areset = 1;
    repeat (2) @(posedge user_clk);
    #1;
    user_areset = 0;
    @(posedge user_clk);
    #1;
  endtask

  initial begin
    int n;
    logic [11:0] ad;
    logic [31:0] d;
    logic [3:0]  s;
    for (int i = 0; i < 1024; i++) begin
      bram_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0001_0103);
      ref_mem[i]  = bram_mem[i];
    end
    bram_mem[12'h804 >> 2] = 32'h1234_5678;
    ref_mem[12'h804 >> 2]  = 32'h1234_5678;
    {s_axil_awvalid, s_axil_wvalid, s_axil_arvalid} = '0;
    s_axil_awaddr = 0; s_axil_araddr = 0; s_axil_wdata = 0; s_axil_wstrb = 0;
    user_areset = 1;
    #2;
    check_reset_outputs("reset");
    repeat (3) @(posedge user_clk);
    #1;
    user_areset = 0;
    @(posedge user_clk);
    #1;

    exp_write(12'h214, 32'hDEAD_BEEF, 4'hF);
    drive_write(12'h214, 32'hDEAD_BEEF, 4'hF);
    wait_idle();
    exp_read(12'h804);
    drive_read(12'h804);
    wait_idle();
    exp_write(12'h300, 32'h0BAD_F00D, 4'h0);
    drive_write(12'h300, 32'h0BAD_F00D, 4'h0);
    wait_idle();

    // Contention from reset: W,R then W,R
    reset_pulse();
    for (int k = 0; k < 2; k++) begin
      exp_write(12'h010 + 12'(k * 8), 32'hC0DE_0000 + k, 4'hF);
      exp_read(12'h010 + 12'(k * 8));
      fork
        drive_write(12'h010 + 12'(k * 8), 32'hC0DE_0000 + k, 4'hF);
        drive_read(12'h010 + 12'(k * 8));
      join
      wait_idle();
    end

    rdy_mode = 2;
    exp_write(12'h044, 32'h5555_AAAA, 4'h3);
    drive_write(12'h044, 32'h5555_AAAA, 4'h3);
    @(negedge user_clk);
    repeat (5) begin @(negedge user_clk); check("bvalid_held", s_axil_bvalid, 1); end
    rdy_mode = 0;
    wait_idle();
    rdy_mode = 3;
    exp_read(12'h044);
    drive_read(12'h044);
    n = 0;
    while (!s_axil_rvalid && n < 50) begin n++; @(negedge user_clk); end
    repeat (5) begin check("rvalid_held", s_axil_rvalid, 1); @(negedge user_clk); end
    rdy_mode = 0;
    wait_idle();

    // Reset in RD_WAIT abandons the read
    acc_q.push_back('{we: 4'h0, addr: 12'h100, wdata: 32'h0});
    drive_read(12'h100);
    @(posedge user_clk);
    #1;
    user_areset = 1;
    #1;
    check_reset_outputs("midread_reset");
    repeat (2) @(posedge user_clk);
    #1;
    user_areset = 0;
    repeat (12) @(posedge user_clk);
    #1;
    exp_read(12'h004);
    drive_read(12'h004);
    wait_idle();

    rdy_mode = 1;
    repeat (40) begin
      ad = 12'($urandom_range(0, 31) << 2) | 12'($urandom_range(0, 3));
      d  = $urandom;
      s  = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 0) begin
        exp_write(ad, d, s);
        drive_write(ad, d, s);
      end else begin
        exp_read(ad);
        drive_read(ad);
      end
    end
    rdy_mode = 0;
    wait_idle();
    check("scoreboard_drained", resp_q.size() + acc_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
